program_loader: RTL
===================

// Module: program_loader
// PURPOSE
// - Write-side counterpart to the instruction fetch path: packs instruction fields (cond, op_code,
//   dest_reg, src_reg1, src_reg2, shift) into 16-bit words and writes them into instruction memory.
// - Sits between a host/bench field source and the memory write port. Asserts run_en once the
//   program is loaded so the fetch/decode/register-bank/ALU path may start.
// PARAMETERS
// - ADDR_W   4    instruction memory address width; memory depth = 2**ADDR_W
// - DATA_W   16   instruction word width; fixed at 16, other values unsupported
// PORTS
// - clk          in   1        system clock, rising edge
// - rst_n        in   1        asynchronous active-low reset
// - start        in   1        pulse: begin a load at base_addr (IDLE/DONE only)
// - abort        in   1        cancel load in progress, return to IDLE
// - base_addr    in   ADDR_W   first write address, sampled on accepted start
// - prog_len     in   ADDR_W+1 instructions to load, sampled on accepted start
// - in_valid     in   1        field bundle valid
// - in_ready     out  1        loader accepts bundle this cycle
// - cond         in   2        condition field
// - op_code      in   4        opcode field
// - dest_reg     in   3        destination register index
// - src_reg1     in   3        source register 1 index
// - src_reg2     in   3        source register 2 index
// - shift        in   7        shift amount
// - use_shift    in   1        1: word[6:0]=shift; 0: word[6:0]={src_reg1,src_reg2,1'b0}
// - wr_en        out  1        memory write strobe
// - wr_addr      out  ADDR_W   memory write address
// - wr_data      out  DATA_W   encoded instruction word
// - loaded_cnt   out  ADDR_W+1 instructions written since last start
// - busy         out  1        state == LOAD
// - run_en       out  1        state == DONE; processor may fetch
// BEHAVIOUR
// - Encoding: word = {cond[15:14], op_code[13:10], dest_reg[9:7], low7[6:0]}; low7 per use_shift.
//   shift overlays src_reg1/src_reg2 exactly as the decoder extracts it.
// - Reset (async, rst_n=0): state IDLE; wr_en, wr_addr, wr_data, loaded_cnt, busy, run_en,
//   in_ready all 0; internal ptr and remaining count 0.
// - FSM IDLE -> LOAD on start (prog_len!=0); IDLE -> DONE on start with prog_len==0.
//   LOAD -> DONE at the edge writing the last word; LOAD -> IDLE on abort.
//   DONE -> LOAD/DONE on start (same rule as IDLE); DONE -> IDLE on abort.
// - start in LOAD ignored. abort wins over start and over a same-cycle transfer.
// - in_ready = (state==LOAD) && !abort (combinational). Transfer = in_valid && in_ready.
// - Latency 1: transfer at edge N -> wr_en=1, wr_addr=ptr, wr_data=encoded word during cycle N+1.
//   Throughput 1 word/cycle; wr_en is a single-cycle strobe per transfer, 0 otherwise.
// - ptr increments modulo 2**ADDR_W per transfer (15 -> 0 wraps, no error); loaded_cnt += 1.
// - Last transfer (loaded_cnt+1 == prog_len) moves to DONE at the same edge; its write still
//   appears in the following cycle; run_en rises in that same cycle.
// - abort: pending write of a same-edge transfer is dropped (no wr_en after abort edge);
//   loaded_cnt holds its value until next start. start clears loaded_cnt to 0.
// - in_valid ignored outside LOAD; field inputs don't-care when no transfer.
// STRUCTURE
// - cpu_isa_pkg: field bit positions/widths (COND_MSB..SHIFT_LSB), state enum {IDLE,LOAD,DONE}.
//   Same package supplies decoder-side slicing so encode/decode cannot drift.
// - Sub-module inst_encoder: combinational field->word pack; instanced once; also reused by bench.
// - Top: FSM, ptr/count registers, registered write port.
// TESTING
// - Reset mid-LOAD with wr_en high -> all outputs 0 immediately, no further writes.
// - start base=0 len=1; cond=1 op=2 dest=3 s1=4 s2=5 use_shift=0 -> wr_addr=0 wr_data=16'h49CA; run_en next.
// - Shift form: cond=0 op=5 dest=1 shift=7'h7F use_shift=1 -> wr_data=16'h14FF.
// - base=14 len=4, in_valid held 1 -> writes at 14,15,0,1 on 4 consecutive cycles; loaded_cnt=4.
// - len=9, in_valid toggled 1/0 -> exactly 9 wr_en strobes, in_ready 0 after the 9th, run_en=1.
// - abort asserted with in_valid=1 on 3rd transfer -> 2 writes only, state IDLE, loaded_cnt=2.
// - start with prog_len=0 -> DONE next cycle, no wr_en; start while busy -> no restart.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared instruction-set definitions: field positions of the 16-bit word,
// loader state encoding, and decoder-side slicing helpers. The encoder and
// the decoder both use these, so the two sides cannot drift apart.
package cpu_isa_pkg;

    localparam int INST_W    = 16;

    localparam int COND_MSB  = 15;
    localparam int COND_LSB  = 14;
    localparam int OP_MSB    = 13;
    localparam int OP_LSB    = 10;
    localparam int DEST_MSB  = 9;
    localparam int DEST_LSB  = 7;
    localparam int SRC1_MSB  = 6;
    localparam int SRC1_LSB  = 4;
    localparam int SRC2_MSB  = 3;
    localparam int SRC2_LSB  = 1;
    // shift overlays both source fields and the spare bit 0
    localparam int SHIFT_MSB = 6;
    localparam int SHIFT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ld_state_e;

    // One instruction's worth of fields as presented by the host
    typedef struct packed {
        logic [1:0] cond;
        logic [3:0] op_code;
        logic [2:0] dest_reg;
        logic [2:0] src_reg1;
        logic [2:0] src_reg2;
        logic [6:0] shift;
        logic       use_shift;
    } inst_fields_t;

    // Decoder-side field extraction
    function automatic logic [1:0] dec_cond(input logic [INST_W-1:0] w);
        return w[COND_MSB:COND_LSB];
    endfunction

    function automatic logic [3:0] dec_op(input logic [INST_W-1:0] w);
        return w[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [2:0] dec_dest(input logic [INST_W-1:0] w);
        return w[DEST_MSB:DEST_LSB];
    endfunction

    function automatic logic [2:0] dec_src1(input logic [INST_W-1:0] w);
        return w[SRC1_MSB:SRC1_LSB];
    endfunction

    function automatic logic [2:0] dec_src2(input logic [INST_W-1:0] w);
        return w[SRC2_MSB:SRC2_LSB];
    endfunction

    function automatic logic [6:0] dec_shift(input logic [INST_W-1:0] w);
        return w[SHIFT_MSB:SHIFT_LSB];
    endfunction

endpackage

// File: rtl/inst_encoder.sv
// Combinational field-to-word packer for the instruction memory format.
module inst_encoder
    import cpu_isa_pkg::*;
(
    input  inst_fields_t      i_fields,
    output logic [INST_W-1:0] o_word
);

    // Place each field at its decoder-visible position; bit 0 is zero in register form
    always_comb begin
        o_word                    = '0;
        o_word[COND_MSB:COND_LSB] = i_fields.cond;
        o_word[OP_MSB:OP_LSB]     = i_fields.op_code;
        o_word[DEST_MSB:DEST_LSB] = i_fields.dest_reg;
        if (i_fields.use_shift) begin
            o_word[SHIFT_MSB:SHIFT_LSB] = i_fields.shift;
        end else begin
            o_word[SRC1_MSB:SRC1_LSB] = i_fields.src_reg1;
            o_word[SRC2_MSB:SRC2_LSB] = i_fields.src_reg2;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: accepts instruction field bundles, encodes them and
// writes them to consecutive instruction memory addresses, then raises
// run_en so the fetch path may start.
module program_loader
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W:0]   i_prog_len,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [1:0]        i_cond,
    input  logic [3:0]        i_op_code,
    input  logic [2:0]        i_dest_reg,
    input  logic [2:0]        i_src_reg1,
    input  logic [2:0]        i_src_reg2,
    input  logic [6:0]        i_shift,
    input  logic              i_use_shift,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic [ADDR_W:0]   o_loaded_cnt,
    output logic              o_busy,
    output logic              o_run_en
);

    ld_state_e         r_state;
    ld_state_e         w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_rem;
    logic [ADDR_W:0]   r_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    inst_fields_t      w_fields;
    logic [INST_W-1:0] w_word;
    logic              w_xfer;
    logic              w_start_acc;
    logic              w_last;

    assign w_fields = '{cond:      i_cond,
                        op_code:   i_op_code,
                        dest_reg:  i_dest_reg,
                        src_reg1:  i_src_reg1,
                        src_reg2:  i_src_reg2,
                        shift:     i_shift,
                        use_shift: i_use_shift};

    inst_encoder u_enc (
        .i_fields (w_fields),
        .o_word   (w_word)
    );

    // A start is honoured only outside LOAD and never alongside abort
    assign w_start_acc = i_start && !i_abort && (r_state != LOAD);
    assign w_xfer      = i_in_valid && o_in_ready;
    assign w_last      = (r_rem == (ADDR_W+1)'(1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state and state-decoded outputs; abort dominates everything
    always_comb begin
        w_next     = r_state;
        o_in_ready = 1'b0;
        o_busy     = 1'b0;
        o_run_en   = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                o_run_en = (r_state == DONE);
                if (i_abort)      w_next = IDLE;
                else if (i_start) w_next = (i_prog_len == '0) ? DONE : LOAD;
            end
            LOAD: begin
                o_busy     = 1'b1;
                o_in_ready = !i_abort;
                if (i_abort)               w_next = IDLE;
                else if (w_xfer && w_last) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Pointer, remaining and loaded counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            r_rem <= '0;
            r_cnt <= '0;
        end else if (w_start_acc) begin
            r_ptr <= i_base_addr;
            r_rem <= i_prog_len;
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_ptr <= r_ptr + 1'b1;
            r_rem <= r_rem - 1'b1;
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered write port: one strobe the cycle after each transfer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_xfer;
            if (w_xfer) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_word;
            end
        end
    end

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_loaded_cnt = r_cnt;

endmodule
